// File: rtl/rob_multi_commit.sv
// Reorder buffer with in-order retire of up to COMMIT_W entries per cycle,
// multi-channel writeback, operand forwarding and mispredict rollback.
module rob_multi_commit #(
  parameter int DEPTH    = 16,
  parameter int PTR_W    = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int WB_CH    = 2,
  parameter int COMMIT_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         issue,
  input  logic [4:0]                   issue_rd,
  input  logic [1:0]                   issue_kind,
  input  logic [ADDR_W-1:0]            issue_pc,
  input  logic                         issue_pred,
  input  logic                         issue_ready,
  output logic [PTR_W-1:0]             nxt_rob_pos,
  output logic                         rob_nxt_full,
  input  logic [WB_CH-1:0]             wb_valid,
  input  logic [WB_CH*PTR_W-1:0]       wb_pos,
  input  logic [WB_CH*DATA_W-1:0]      wb_val,
  input  logic [WB_CH-1:0]             wb_jump,
  input  logic [WB_CH*ADDR_W-1:0]      wb_tgt,
  input  logic [2*PTR_W-1:0]           q_pos,
  output logic [1:0]                   q_ready,
  output logic [2*DATA_W-1:0]          q_val,
  output logic [PTR_W-1:0]             head_rob_pos,
  output logic [COMMIT_W-1:0]          cm_valid,
  output logic [COMMIT_W*PTR_W-1:0]    cm_pos,
  output logic [COMMIT_W-1:0]          reg_we,
  output logic [COMMIT_W*5-1:0]        reg_rd,
  output logic [COMMIT_W*DATA_W-1:0]   reg_val,
  output logic                         lsb_store,
  output logic                         br_upd,
  output logic                         br_jump,
  output logic [ADDR_W-1:0]            br_pc,
  output logic                         rollback,
  output logic                         set_pc_en,
  output logic [ADDR_W-1:0]            set_pc
);

  localparam logic [1:0] K_ALU  = 2'd0;
  localparam logic [1:0] K_ST   = 2'd1;
  localparam logic [1:0] K_BR   = 2'd2;
  localparam logic [1:0] K_JALR = 2'd3;
  localparam int CW = PTR_W + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [DEPTH-1:0]  pred_q, pred_d;
  logic [DEPTH-1:0]  jump_q, jump_d;
  logic [1:0]        kind_q [DEPTH];
  logic [1:0]        kind_d [DEPTH];
  logic [4:0]        rd_q   [DEPTH];
  logic [4:0]        rd_d   [DEPTH];
  logic [DATA_W-1:0] val_q  [DEPTH];
  logic [DATA_W-1:0] val_d  [DEPTH];
  logic [ADDR_W-1:0] tgt_q  [DEPTH];
  logic [ADDR_W-1:0] tgt_d  [DEPTH];

  logic [COMMIT_W-1:0]        cm_valid_q, cm_valid_d;
  logic [COMMIT_W*PTR_W-1:0]  cm_pos_q, cm_pos_d;
  logic [COMMIT_W-1:0]        reg_we_q, reg_we_d;
  logic [COMMIT_W*5-1:0]      reg_rd_q, reg_rd_d;
  logic [COMMIT_W*DATA_W-1:0] reg_val_q, reg_val_d;
  logic                       lsb_store_q, lsb_store_d;
  logic                       br_upd_q, br_upd_d;
  logic                       br_jump_q, br_jump_d;
  logic [ADDR_W-1:0]          br_pc_q, br_pc_d;
  logic                       rollback_q, rollback_d;
  logic                       set_pc_en_q, set_pc_en_d;
  logic [ADDR_W-1:0]          set_pc_q, set_pc_d;

  logic [PTR_W-1:0] h1;
  logic             ret0, ret1, mis, iss_ok;
  logic [1:0]       lane_v;

  // Retire decision; nothing retires while the flush is in progress.
  always_comb begin
    h1   = head_q + PTR_W'(1);
    ret0 = !rollback_q && (count_q != '0)
         && ready_q[head_q];
    ret1 = (COMMIT_W == 2) && ret0
         && (count_q >= CW'(2)) && ready_q[h1]
         && (kind_q[head_q] == K_ALU)
         && (kind_q[h1] == K_ALU);
    mis  = ret0
         && ((kind_q[head_q] == K_BR)
          || (kind_q[head_q] == K_JALR))
         && (pred_q[head_q] != jump_q[head_q]);
    iss_ok = issue && !rollback_q
           && ((count_q != FULL) || ret0);
    lane_v = {ret1, ret0};
  end

  always_comb begin : lanes
    logic [PTR_W-1:0] lp;
    lp          = '0;
    cm_valid_d  = '0;
    cm_pos_d    = '0;
    reg_we_d    = '0;
    reg_rd_d    = '0;
    reg_val_d   = '0;
    for (int l = 0; l < COMMIT_W; l++) begin
      lp = head_q + PTR_W'(l);
      if (lane_v[l]) begin
        cm_valid_d[l] = 1'b1;
        cm_pos_d[l*PTR_W +: PTR_W] = lp;
        reg_we_d[l] = (kind_q[lp] == K_ALU)
                   || (kind_q[lp] == K_JALR);
        reg_rd_d[l*5 +: 5] = rd_q[lp];
        reg_val_d[l*DATA_W +: DATA_W] = val_q[lp];
      end
    end
    lsb_store_d = ret0 && (kind_q[head_q] == K_ST);
    br_upd_d    = ret0 && (kind_q[head_q] == K_BR);
    br_jump_d   = br_upd_d && jump_q[head_q];
    br_pc_d     = br_upd_d ? tgt_q[head_q] : '0;
    rollback_d  = mis;
    set_pc_en_d = mis;
    set_pc_d    = mis ? tgt_q[head_q] : '0;
  end

  always_comb begin : next_state
    logic [PTR_W-1:0] wp;
    wp      = '0;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ready_d = ready_q;
    pred_d  = pred_q;
    jump_d  = jump_q;
    kind_d  = kind_q;
    rd_d    = rd_q;
    val_d   = val_q;
    tgt_d   = tgt_q;
    if (rollback_q) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ready_d = '0;
    end else begin
      if (ret0) ready_d[head_q] = 1'b0;
      if (ret1) ready_d[h1] = 1'b0;
      head_d = head_q + PTR_W'(ret0) + PTR_W'(ret1);
      // Descending so the lowest channel wins a collision.
      for (int c = WB_CH - 1; c >= 0; c--) begin
        if (wb_valid[c]) begin
          wp = wb_pos[c*PTR_W +: PTR_W];
          ready_d[wp] = 1'b1;
          val_d[wp]   = wb_val[c*DATA_W +: DATA_W];
          jump_d[wp]  = wb_jump[c];
          tgt_d[wp]   = wb_tgt[c*ADDR_W +: ADDR_W];
        end
      end
      if (iss_ok) begin
        ready_d[tail_q] = issue_ready;
        kind_d[tail_q]  = issue_kind;
        rd_d[tail_q]    = issue_rd;
        pred_d[tail_q]  = issue_pred;
        jump_d[tail_q]  = 1'b0;
        val_d[tail_q]   = '0;
        tgt_d[tail_q]   = issue_pc + ADDR_W'(4);
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CW'(iss_ok)
              - CW'(ret0) - CW'(ret1);
    end
  end

  always_comb begin : query
    logic [PTR_W-1:0]  qp;
    logic [DATA_W-1:0] qv;
    logic              qh;
    qp      = '0;
    qv      = '0;
    qh      = 1'b0;
    q_ready = '0;
    q_val   = '0;
    for (int i = 0; i < 2; i++) begin
      qp = q_pos[i*PTR_W +: PTR_W];
      qh = 1'b0;
      qv = val_q[qp];
      for (int c = WB_CH - 1; c >= 0; c--) begin
        if (wb_valid[c]
            && (wb_pos[c*PTR_W +: PTR_W] == qp)) begin
          qh = 1'b1;
          qv = wb_val[c*DATA_W +: DATA_W];
        end
      end
      q_ready[i] = ready_q[qp] | qh;
      q_val[i*DATA_W +: DATA_W] = qv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ready_q     <= '0;
      cm_valid_q  <= '0;
      cm_pos_q    <= '0;
      reg_we_q    <= '0;
      reg_rd_q    <= '0;
      reg_val_q   <= '0;
      lsb_store_q <= 1'b0;
      br_upd_q    <= 1'b0;
      br_jump_q   <= 1'b0;
      br_pc_q     <= '0;
      rollback_q  <= 1'b0;
      set_pc_en_q <= 1'b0;
      set_pc_q    <= '0;
    end else if (rdy) begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      cm_valid_q  <= cm_valid_d;
      cm_pos_q    <= cm_pos_d;
      reg_we_q    <= reg_we_d;
      reg_rd_q    <= reg_rd_d;
      reg_val_q   <= reg_val_d;
      lsb_store_q <= lsb_store_d;
      br_upd_q    <= br_upd_d;
      br_jump_q   <= br_jump_d;
      br_pc_q     <= br_pc_d;
      rollback_q  <= rollback_d;
      set_pc_en_q <= set_pc_en_d;
      set_pc_q    <= set_pc_d;
    end
  end

  // Payload arrays are only meaningful under ready/count; no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      pred_q <= pred_d;
      jump_q <= jump_d;
      kind_q <= kind_d;
      rd_q   <= rd_d;
      val_q  <= val_d;
      tgt_q  <= tgt_d;
    end
  end

  assign nxt_rob_pos  = tail_q;
  assign head_rob_pos = head_q;
  assign rob_nxt_full = rdy ? (count_d == FULL)
                            : (count_q == FULL);
  assign cm_valid     = cm_valid_q;
  assign cm_pos       = cm_pos_q;
  assign reg_we       = reg_we_q;
  assign reg_rd       = reg_rd_q;
  assign reg_val      = reg_val_q;
  assign lsb_store    = lsb_store_q;
  assign br_upd       = br_upd_q;
  assign br_jump      = br_jump_q;
  assign br_pc        = br_pc_q;
  assign rollback     = rollback_q;
  assign set_pc_en    = set_pc_en_q;
  assign set_pc       = set_pc_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Randomized bench for rob_multi_commit against a queue-based ROB model.
// Directed scenarios first, then long random runs with wrap and rollback.
module tb_rob_multi_commit;
  localparam int D = 16;

  logic        clk, rst, rdy;
  logic        issue;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_kind;
  logic [31:0] issue_pc;
  logic        issue_pred, issue_ready;
  logic [3:0]  nxt_rob_pos;
  logic        rob_nxt_full;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_pos;
  logic [63:0] wb_val;
  logic [1:0]  wb_jump;
  logic [63:0] wb_tgt;
  logic [7:0]  q_pos;
  logic [1:0]  q_ready;
  logic [63:0] q_val;
  logic [3:0]  head_rob_pos;
  logic [1:0]  cm_valid;
  logic [7:0]  cm_pos;
  logic [1:0]  reg_we;
  logic [9:0]  reg_rd;
  logic [63:0] reg_val;
  logic        lsb_store, br_upd, br_jump;
  logic [31:0] br_pc;
  logic        rollback, set_pc_en;
  logic [31:0] set_pc;

  rob_multi_commit dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue(issue), .issue_rd(issue_rd),
    .issue_kind(issue_kind), .issue_pc(issue_pc),
    .issue_pred(issue_pred),
    .issue_ready(issue_ready),
    .nxt_rob_pos(nxt_rob_pos),
    .rob_nxt_full(rob_nxt_full),
    .wb_valid(wb_valid), .wb_pos(wb_pos),
    .wb_val(wb_val), .wb_jump(wb_jump),
    .wb_tgt(wb_tgt),
    .q_pos(q_pos), .q_ready(q_ready), .q_val(q_val),
    .head_rob_pos(head_rob_pos),
    .cm_valid(cm_valid), .cm_pos(cm_pos),
    .reg_we(reg_we), .reg_rd(reg_rd),
    .reg_val(reg_val),
    .lsb_store(lsb_store), .br_upd(br_upd),
    .br_jump(br_jump), .br_pc(br_pc),
    .rollback(rollback), .set_pc_en(set_pc_en),
    .set_pc(set_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          pos;
    logic [4:0]  rd;
    logic [1:0]  kind;
    logic        pred;
    logic        rdy;
    logic [31:0] val;
    logic        jump;
    logic [31:0] tgt;
  } ent_t;

  ent_t rob[$];
  int   mhead;
  bit   mrb;
  bit   no_br;

  logic [1:0]  x_cmv, x_we;
  logic [7:0]  x_cmpos;
  logic [9:0]  x_rd;
  logic [63:0] x_val;
  logic        x_st, x_bu, x_bj, x_rb, x_spe;
  logic [31:0] x_bpc, x_sp;

  int checks, errors;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic zero_x();
    x_cmv = '0; x_we = '0; x_cmpos = '0; x_rd = '0;
    x_val = '0; x_st = 0; x_bu = 0; x_bj = 0;
    x_rb = 0; x_spe = 0; x_bpc = '0; x_sp = '0;
  endtask

  task automatic check_comb();
    int p;
    bit hit, found, er;
    logic [31:0] ev;
    chk("nxt_pos", nxt_rob_pos, 64'((mhead + rob.size()) % D));
    chk("head_pos", head_rob_pos, 64'(mhead));
    for (int i = 0; i < 2; i++) begin
      p = int'(q_pos[i*4 +: 4]);
      hit = 0; found = 0; er = 0; ev = '0;
      for (int c = 1; c >= 0; c--)
        if (wb_valid[c] && int'(wb_pos[c*4 +: 4]) == p) begin
          hit = 1; ev = wb_val[c*32 +: 32];
        end
      if (!hit)
        foreach (rob[k])
          if (rob[k].pos == p) begin
            found = 1; er = rob[k].rdy; ev = rob[k].val;
          end
      if (hit) er = 1;
      if (hit || found) begin
        chk($sformatf("q_ready%0d", i), q_ready[i], er);
        if (er) chk($sformatf("q_val%0d", i), q_val[i*32 +: 32], ev);
      end
    end
  endtask

  task automatic model_step();
    bit r0, r1, mis;
    int n, p;
    ent_t e;
    if (rst) begin
      rob.delete(); mhead = 0; mrb = 0; zero_x();
      return;
    end
    if (!rdy) begin
      chk("nxt_full", rob_nxt_full, rob.size() == D);
      return;
    end
    if (mrb) begin
      chk("nxt_full", rob_nxt_full, 0);
      rob.delete(); mhead = 0; mrb = 0; zero_x();
      return;
    end
    zero_x();
    r0 = rob.size() > 0 && rob[0].rdy;
    r1 = r0 && rob.size() >= 2 && rob[1].rdy
       && rob[0].kind == 0 && rob[1].kind == 0;
    n = r0 + r1;
    for (int l = 0; l < n; l++) begin
      e = rob[l];
      x_cmv[l] = 1;
      x_cmpos[l*4 +: 4] = 4'(e.pos);
      x_we[l] = (e.kind == 0 || e.kind == 3);
      x_rd[l*5 +: 5] = e.rd;
      x_val[l*32 +: 32] = e.val;
    end
    if (r0) begin
      e = rob[0];
      x_st = (e.kind == 1);
      x_bu = (e.kind == 2);
      if (x_bu) begin x_bj = e.jump; x_bpc = e.tgt; end
      mis = (e.kind >= 2) && (e.pred != e.jump);
      if (mis) begin x_rb = 1; x_spe = 1; x_sp = e.tgt; end
    end
    repeat (n) void'(rob.pop_front());
    mhead = (mhead + n) % D;
    for (int c = 1; c >= 0; c--)
      if (wb_valid[c]) begin
        p = int'(wb_pos[c*4 +: 4]);
        foreach (rob[k])
          if (rob[k].pos == p) begin
            e = rob[k];
            e.rdy = 1; e.val = wb_val[c*32 +: 32];
            e.jump = wb_jump[c]; e.tgt = wb_tgt[c*32 +: 32];
            rob[k] = e;
          end
      end
    if (issue && rob.size() < D) begin
      e.pos = (mhead + rob.size()) % D;
      e.rd = issue_rd; e.kind = issue_kind;
      e.pred = issue_pred; e.rdy = issue_ready;
      e.val = '0; e.jump = 0; e.tgt = issue_pc + 32'd4;
      rob.push_back(e);
    end
    chk("nxt_full", rob_nxt_full, rob.size() == D);
    mrb = x_rb;
  endtask

  task automatic check_regs();
    chk("cm_valid", cm_valid, x_cmv);
    chk("cm_pos", cm_pos, x_cmpos);
    chk("reg_we", reg_we, x_we);
    chk("reg_rd", reg_rd, x_rd);
    chk("reg_val", reg_val, x_val);
    chk("lsb_store", lsb_store, x_st);
    chk("br_upd", br_upd, x_bu);
    chk("br_jump", br_jump, x_bj);
    chk("br_pc", br_pc, x_bpc);
    chk("rollback", rollback, x_rb);
    chk("set_pc_en", set_pc_en, x_spe);
    chk("set_pc", set_pc, x_sp);
    chk("head_after", head_rob_pos, 64'(mhead));
    chk("tail_after", nxt_rob_pos, 64'((mhead + rob.size()) % D));
  endtask

  task automatic cycle();
    #2;
    if (!rst) check_comb();
    model_step();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic idle();
    rst = 0; rdy = 1; issue = 0; issue_rd = '0;
    issue_kind = '0; issue_pc = '0; issue_pred = 0;
    issue_ready = 0; wb_valid = '0; wb_pos = '0;
    wb_val = '0; wb_jump = '0; wb_tgt = '0; q_pos = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); cycle(); rst = 0;
  endtask

  task automatic iss(logic [1:0] k, logic [4:0] rd,
                     logic pr, logic rr);
    issue = 1; issue_kind = k; issue_rd = rd;
    issue_pred = pr; issue_ready = rr;
    issue_pc = {$urandom_range(0, 1023), 2'b00};
  endtask

  task automatic rand_inputs();
    int cand[$];
    int idx, k, r;
    idle();
    rdy = ($urandom_range(0, 9) != 0);
    issue = ($urandom_range(0, 99) < 60);
    r = $urandom_range(0, 9);
    issue_kind = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 :
                 no_br ? 2'd0 : (r == 8) ? 2'd2 : 2'd3;
    issue_rd = 5'($urandom);
    issue_pc = $urandom & 32'hFFFF_FFFC;
    issue_pred = 1'($urandom);
    issue_ready = (issue_kind < 2) && ($urandom_range(0, 2) == 0);
    foreach (rob[j]) if (!rob[j].rdy) cand.push_back(j);
    for (int c = 0; c < 2; c++)
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, cand.size() - 1);
        k = cand[idx];
        cand.delete(idx);
        wb_valid[c] = 1;
        wb_pos[c*4 +: 4] = 4'(rob[k].pos);
        wb_val[c*32 +: 32] = $urandom;
        wb_tgt[c*32 +: 32] = $urandom & 32'hFFFF_FFFC;
        if (rob[k].kind >= 2)
          wb_jump[c] = ($urandom_range(0, 99) < 85)
                     ? rob[k].pred : !rob[k].pred;
        else
          wb_jump[c] = 1'($urandom);
      end
    for (int i = 0; i < 2; i++)
      if (wb_valid[i] && $urandom_range(0, 1) == 1)
        q_pos[i*4 +: 4] = wb_pos[i*4 +: 4];
      else if (rob.size() > 0)
        q_pos[i*4 +: 4] = 4'(rob[$urandom_range(0, rob.size() - 1)].pos);
      else
        q_pos[i*4 +: 4] = 4'($urandom);
  endtask

  initial begin
    checks = 0; errors = 0;
    rob.delete(); mhead = 0; mrb = 0; no_br = 1;
    zero_x();
    do_reset();

    // Fill to full with pending ALU ops; the 17th issue is dropped.
    for (int i = 0; i < 17; i++) begin
      idle(); iss(2'd0, 5'(i + 1), 0, 0); cycle();
    end
    chk("full_flag", rob_nxt_full, 1);

    // Same-cycle forward on channel 1.
    idle();
    wb_valid = 2'b10; wb_pos[7:4] = 4'd5;
    wb_val[63:32] = 32'hAB; q_pos[3:0] = 4'd5;
    cycle();

    // Complete two at head, then dual retire while issuing into full ROB.
    idle();
    wb_valid = 2'b11; wb_pos = 8'h10;
    wb_val = {32'h22, 32'h11};
    cycle();
    idle(); iss(2'd0, 5'd30, 0, 1); cycle();
    idle(); cycle();

    // Store at head with ready ALU behind it.
    do_reset();
    idle(); iss(2'd1, 5'd3, 0, 0); cycle();
    idle(); iss(2'd0, 5'd4, 0, 1); cycle();
    idle(); wb_valid = 2'b01; wb_pos = 8'h00; cycle();
    idle(); cycle();
    idle(); cycle();

    // Mispredicted branch, issue attempted during the flush.
    do_reset();
    idle(); iss(2'd2, 5'd0, 0, 0); cycle();
    idle(); iss(2'd0, 5'd7, 0, 1); cycle();
    idle(); wb_valid = 2'b01; wb_pos = 8'h00;
    wb_jump = 2'b01; wb_tgt[31:0] = 32'h100; cycle();
    idle(); cycle();
    idle(); iss(2'd0, 5'd9, 0, 1); cycle();
    idle(); cycle();

    // Random: long branch-free phase for wrap, then full mix.
    do_reset();
    no_br = 1;
    for (int i = 0; i < 400; i++) begin rand_inputs(); cycle(); end
    no_br = 0;
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      if (i == 700) rst = 1;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
